// File: rtl/burst_read_responder_if.sv
// AXI4 read address and read data channels between a requester (master) and burst_read_responder (slave).
interface burst_read_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    modport master (output araddr, arvalid, arlen, arburst, rready,
                    input  arready, rdata, rresp, rvalid, rlast);
    modport slave  (input  araddr, arvalid, arlen, arburst, rready,
                    output arready, rdata, rresp, rvalid, rlast);
endinterface

// File: rtl/burst_read_responder.sv
// AXI4 read-only subordinate returning FIXED/INCR/WRAP bursts from an internal word memory,
// with configurable first-beat and inter-beat latency to mimic SRAM/flash timing.
module burst_read_responder #(
    parameter int          MEM_WORDS_DIG = 12,
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          FIRST_LAT     = 2,
    parameter int          BEAT_LAT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    burst_read_responder_if.slave    bus,
    input  logic                     ld_we,
    input  logic [MEM_WORDS_DIG-1:0] ld_waddr,
    input  logic [31:0]              ld_wdata
);
    localparam int          MEM_WORDS  = 1 << MEM_WORDS_DIG;
    localparam logic [32:0] MEM_BYTES  = 33'(MEM_WORDS) << 2;
    // LAT is only entered for nonzero latency and spends (latency) cycles there, counting down to zero.
    localparam logic [7:0]  FIRST_WAIT = (FIRST_LAT > 0) ? 8'(FIRST_LAT - 1) : 8'd0;
    localparam logic [7:0]  BEAT_WAIT  = (BEAT_LAT > 0) ? 8'(BEAT_LAT - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, LAT, DATA} state_t;
    state_t state_q, state_d;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] addr_q, rdata_q;
    logic [7:0]  len_q, beat_q, lat_q;
    logic [1:0]  burst_q, rresp_q;
    logic        slv_err_q, rlast_q;

    logic        accept_ar, take_beat, load;
    logic        ar_slv, cur_slv, rd_in_range;
    logic [31:0] wrap_mask, adv_addr, rd_addr, rd_off;
    logic [7:0]  cur_len, beat_d;

    assign ar_slv = (bus.arburst == 2'b11) ||
                    ((bus.arburst == 2'b10) && !((bus.arlen == 8'd1) || (bus.arlen == 8'd3) ||
                                                 (bus.arlen == 8'd7) || (bus.arlen == 8'd15)));

    assign wrap_mask = ({24'd0, len_q} << 2) + 32'd3;

    always_comb begin
        adv_addr = addr_q + 32'd4;
        case (burst_q)
            2'b00:   adv_addr = addr_q;
            2'b10:   adv_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
            default: adv_addr = addr_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        accept_ar = 1'b0;
        take_beat = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.arvalid) begin
                    accept_ar = 1'b1;
                    load      = (FIRST_LAT == 0);
                    state_d   = (FIRST_LAT == 0) ? DATA : LAT;
                end
            end
            LAT: begin
                if (lat_q == 8'd0) begin
                    load    = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        take_beat = 1'b1;
                        load      = (BEAT_LAT == 0);
                        state_d   = (BEAT_LAT == 0) ? DATA : LAT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The beat being fetched may come straight from the AR channel or from the just-advanced address.
    assign rd_addr     = accept_ar ? (bus.araddr & ~32'd3) : (take_beat ? adv_addr : addr_q);
    assign cur_len     = accept_ar ? bus.arlen : len_q;
    assign cur_slv     = accept_ar ? ar_slv : slv_err_q;
    assign beat_d      = accept_ar ? 8'd0 : (take_beat ? beat_q + 8'd1 : beat_q);
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = {1'b0, rd_off} < MEM_BYTES;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            slv_err_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_ar || take_beat) begin
                addr_q <= rd_addr;
                beat_q <= beat_d;
            end
            if (accept_ar) begin
                len_q     <= bus.arlen;
                burst_q   <= bus.arburst;
                slv_err_q <= ar_slv;
                lat_q     <= FIRST_WAIT;
            end else if (take_beat) begin
                lat_q <= BEAT_WAIT;
            end else if (state_q == LAT && lat_q != 8'd0) begin
                lat_q <= lat_q - 8'd1;
            end
            if (load) begin
                rlast_q <= (beat_d == cur_len);
                if (cur_slv) begin
                    rresp_q <= 2'b10;
                    rdata_q <= '0;
                end else if (!rd_in_range) begin
                    rresp_q <= 2'b11;
                    rdata_q <= '0;
                end else begin
                    rresp_q <= 2'b00;
                    rdata_q <= mem[rd_off[MEM_WORDS_DIG+1:2]];
                end
            end
        end
    end

    // Preload port: the memory itself is never reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_waddr] <= ld_wdata;
        end
    end

    assign bus.arready = (state_q == IDLE);
    assign bus.rvalid  = (state_q == DATA);
    assign bus.rlast   = rlast_q && (state_q == DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_burst_read_responder.sv
// Bench for burst_read_responder: a burst-level expectation queue checked on every valid beat,
// plus directed latency, stall, error, reset and inter-beat-gap cases with literal values.
module tb_burst_read_responder;
    localparam int          MEM_WORDS_DIG = 12;
    localparam int          MEM_WORDS     = 1 << MEM_WORDS_DIG;
    localparam logic [31:0] BASE          = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_we = 1'b0;
    logic [11:0] ld_waddr = '0;
    logic [31:0] ld_wdata = '0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] shadow [MEM_WORDS];
    beat_t       exp_q[$];
    beat_t       got_q[$];

    burst_read_responder_if bus_a();
    burst_read_responder_if bus_b();

    burst_read_responder #(.MEM_WORDS_DIG(MEM_WORDS_DIG), .BASE_ADDR(BASE), .FIRST_LAT(2), .BEAT_LAT(0)) dut (
        .clk(clk), .rst(rst), .bus(bus_a), .ld_we(ld_we), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata));

    burst_read_responder #(.MEM_WORDS_DIG(MEM_WORDS_DIG), .BASE_ADDR(BASE), .FIRST_LAT(2), .BEAT_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .ld_we(ld_we), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Expected beats of a burst, derived directly from the addressing and error rules.
    task automatic expectBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] size;
        logic        slv;
        beat_t       b;
        a    = addr & ~32'd3;
        size = (32'(len) + 32'd1) * 32'd4;
        slv  = (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        for (int i = 0; i <= int'(len); i++) begin
            b.last = (i == int'(len));
            if (slv) begin
                b.resp = 2'b10;
                b.data = '0;
            end else if (a < BASE || a >= BASE + 32'(MEM_WORDS * 4)) begin
                b.resp = 2'b11;
                b.data = '0;
            end else begin
                b.resp = 2'b00;
                b.data = shadow[(a - BASE) / 4];
            end
            exp_q.push_back(b);
            case (burst)
                2'b00:   a = a;
                2'b10:   a = (a & ~(size - 32'd1)) | ((a + 32'd4) & (size - 32'd1));
                default: a = a + 32'd4;
            endcase
        end
    endtask

    // Issue one AR request on bus_a and return just after the handshake edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        bus_a.araddr  = addr;
        bus_a.arlen   = len;
        bus_a.arburst = burst;
        bus_a.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus_a.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ar_accept", 32'(bus_a.arready), 32'd1);
        expectBurst(addr, len, burst);
        @(posedge clk);
        #1 bus_a.arvalid = 1'b0;
    endtask

    task automatic waitDrain(input logic [3:0] pat, output int cycles);
        cycles = 0;
        while (!(exp_q.size() == 0 && bus_a.arready) && cycles < 300) begin
            bus_a.rready = pat[cycles % 4];
            @(posedge clk);
            #1;
            cycles++;
        end
        bus_a.rready = 1'b1;
        checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Compare process: every presented beat must match the head of the expectation queue.
    initial begin
        beat_t g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                checkOutput("rvalid_in_reset", 32'(bus_a.rvalid), 32'd0);
            end else if (bus_a.rvalid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(bus_a.rvalid), 32'd0);
                end else begin
                    checkOutput("beat_rdata", bus_a.rdata, exp_q[0].data);
                    checkOutput("beat_rresp", 32'(bus_a.rresp), 32'(exp_q[0].resp));
                    checkOutput("beat_rlast", 32'(bus_a.rlast), 32'(exp_q[0].last));
                    if (bus_a.rready) begin
                        g.data = bus_a.rdata;
                        g.resp = bus_a.rresp;
                        g.last = bus_a.rlast;
                        got_q.push_back(g);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int          lat;
        int          cyc;
        int          n;
        int          beat;
        logic [6:0]  gap_pat;
        bus_a.araddr = '0; bus_a.arlen = '0; bus_a.arburst = 2'b01; bus_a.arvalid = 1'b0; bus_a.rready = 1'b1;
        bus_b.araddr = '0; bus_b.arlen = '0; bus_b.arburst = 2'b01; bus_b.arvalid = 1'b0; bus_b.rready = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_arready", 32'(bus_a.arready), 32'd1);
        checkOutput("reset_rlast", 32'(bus_a.rlast), 32'd0);
        checkOutput("reset_rresp", 32'(bus_a.rresp), 32'd0);
        checkOutput("reset_rdata", bus_a.rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) begin
            ld_we     = 1'b1;
            ld_waddr  = 12'(i);
            ld_wdata  = 32'(i) * 32'h11;
            shadow[i] = 32'(i) * 32'h11;
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0;

        $display("[TB] INCR 16-beat burst, rready held high");
        got_q.delete();
        applyStimulus(32'h8000_0040, 8'd15, 2'b01);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.rvalid && lat < 20);
        checkOutput("t1_first_lat", 32'(lat), 32'd3);
        waitDrain(4'b1111, cyc);
        checkOutput("t1_burst_cycles", 32'(cyc), 32'd16);
        checkOutput("t1_beats", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            checkOutput("t1_beat0", got_q[0].data, 32'h110);
            checkOutput("t1_beat15", got_q[15].data, 32'h20F);
            checkOutput("t1_last15", 32'(got_q[15].last), 32'd1);
            checkOutput("t1_last14", 32'(got_q[14].last), 32'd0);
        end

        $display("[TB] INCR burst with rready stalls");
        got_q.delete();
        applyStimulus(32'h8000_0040, 8'd15, 2'b01);
        waitDrain(4'b1001, cyc);
        checkOutput("t2_beats", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) begin
            checkOutput("t2_beat1", got_q[1].data, 32'h121);
            checkOutput("t2_beat15", got_q[15].data, 32'h20F);
        end

        $display("[TB] WRAP 4-beat burst");
        got_q.delete();
        applyStimulus(32'h8000_0008, 8'd3, 2'b10);
        waitDrain(4'b1111, cyc);
        checkOutput("t3_beats", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            checkOutput("t3_beat0", got_q[0].data, 32'h22);
            checkOutput("t3_beat1", got_q[1].data, 32'h33);
            checkOutput("t3_beat2", got_q[2].data, 32'h00);
            checkOutput("t3_beat3", got_q[3].data, 32'h11);
            checkOutput("t3_last3", 32'(got_q[3].last), 32'd1);
        end

        $display("[TB] FIXED burst, decode error, slave error");
        got_q.delete();
        applyStimulus(32'h8000_0010, 8'd2, 2'b00);
        waitDrain(4'b1111, cyc);
        checkOutput("t4_fixed_beats", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            checkOutput("t4_fixed_beat2", got_q[2].data, 32'h44);
        end
        got_q.delete();
        applyStimulus(32'h7FFF_FFFC, 8'd1, 2'b01);
        waitDrain(4'b1111, cyc);
        checkOutput("t4_dec_beats", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            checkOutput("t4_dec_resp0", 32'(got_q[0].resp), 32'd3);
            checkOutput("t4_dec_resp1", 32'(got_q[1].resp), 32'd0);
        end
        got_q.delete();
        applyStimulus(32'h8000_0000, 8'd0, 2'b11);
        waitDrain(4'b1111, cyc);
        checkOutput("t4_slv_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            checkOutput("t4_slv_resp", 32'(got_q[0].resp), 32'd2);
            checkOutput("t4_slv_last", 32'(got_q[0].last), 32'd1);
        end

        $display("[TB] reset in the middle of a burst");
        got_q.delete();
        applyStimulus(32'h8000_0000, 8'd15, 2'b01);
        n = 0;
        while (got_q.size() < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5_beats_before_reset", 32'(got_q.size()), 32'd5);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_rvalid_async", 32'(bus_a.rvalid), 32'd0);
        checkOutput("t5_rdata_async", bus_a.rdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_arready_after", 32'(bus_a.arready), 32'd1);
        checkOutput("t5_rvalid_after", 32'(bus_a.rvalid), 32'd0);
        got_q.delete();
        @(posedge clk);
        #1;
        applyStimulus(32'h8000_0100, 8'd0, 2'b01);
        waitDrain(4'b1111, cyc);
        checkOutput("t5_new_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            checkOutput("t5_new_data", got_q[0].data, 32'h440);
            checkOutput("t5_new_last", 32'(got_q[0].last), 32'd1);
        end

        $display("[TB] one idle cycle between beats");
        bus_b.araddr  = 32'h8000_0020;
        bus_b.arlen   = 8'd3;
        bus_b.arburst = 2'b01;
        bus_b.arvalid = 1'b1;
        @(negedge clk);
        checkOutput("t6_ar_accept", 32'(bus_b.arready), 32'd1);
        @(posedge clk);
        #1 bus_b.arvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.rvalid && n < 20);
        checkOutput("t6_first_lat", 32'(n), 32'd3);
        gap_pat = 7'b1010101;
        beat = 0;
        for (int i = 0; i < 7; i++) begin
            checkOutput("t6_rvalid", 32'(bus_b.rvalid), 32'(gap_pat[i]));
            checkOutput("t6_arready", 32'(bus_b.arready), 32'd0);
            if (bus_b.rvalid) begin
                checkOutput("t6_rdata", bus_b.rdata, 32'h88 + 32'h11 * 32'(beat));
                checkOutput("t6_rlast", 32'(bus_b.rlast), 32'(beat == 3));
                beat++;
            end
            @(negedge clk);
        end
        checkOutput("t6_arready_end", 32'(bus_b.arready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
